// File: rtl/act_index_pingpong_buf.sv
// ============================================================================
// Module   : act_index_pingpong_buf
// Purpose  : Two-bank (ping-pong) activation index store. The encoder fills one
//            bank while the PE array reads the other. Optional output register
//            enabled by macro ACT_IDX_OUT_REG_EN.
// Revision : 1.0 - initial parametrised two-bank release
// ============================================================================
`default_nettype none

module act_index_pingpong_buf #(
   parameter int DWIDTH   = 56,
   parameter int AWIDTH   = 7,
   parameter int MEM_SIZE = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [AWIDTH-1:0] wr_addr,
   input  logic [DWIDTH-1:0] wr_data,
   input  logic              wr_last,
   output logic              wr_ready,
   input  logic              rd_en,
   input  logic [AWIDTH-1:0] rd_addr,
   output logic [DWIDTH-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_avail,
   output logic [AWIDTH:0]   rd_len,
   input  logic              rd_done,
   output logic              err
);

   localparam logic [AWIDTH:0] C_MEM_SIZE = (AWIDTH+1)'(MEM_SIZE);

   typedef enum logic {
      FREE = 1'b0,
      FULL = 1'b1
   } bank_state_t;

   bank_state_t       r_state [2];
   bank_state_t       w_state_nxt [2];
   logic              r_wb;
   logic              r_rb;
   logic [AWIDTH:0]   r_wcnt;
   logic [AWIDTH:0]   r_len [2];
   logic [AWIDTH:0]   w_wcnt_inc;
   logic              r_err;

   logic              w_addr_ok;
   logic              w_wr_acc;
   logic              w_commit;
   logic              w_rd_acc;
   logic              w_release;
   logic              w_any_err;

   logic              r_rd_valid;
   logic              r_rd_sel;
   logic              r_rd_any;
   logic [DWIDTH-1:0] w_bank_q [2];
   logic [DWIDTH-1:0] w_ram_data;

   // ------------------------------------------------------------------------
   // Handshake decode
   // ------------------------------------------------------------------------
   assign wr_ready   = (r_state[r_wb] == FREE);
   assign rd_avail   = (r_state[r_rb] == FULL);
   assign w_addr_ok  = ({1'b0, wr_addr} < C_MEM_SIZE);
   assign w_wr_acc   = wr_en & wr_ready & w_addr_ok;
   assign w_commit   = w_wr_acc & wr_last;
   assign w_rd_acc   = rd_en & rd_avail;
   assign w_release  = rd_done & rd_avail;
   assign w_any_err  = (wr_en & ~(wr_ready & w_addr_ok))
                     | (rd_en & ~rd_avail)
                     | (rd_done & ~rd_avail);
   assign w_wcnt_inc = (r_wcnt == C_MEM_SIZE) ? r_wcnt : r_wcnt + 1'b1;

   assign rd_len = rd_avail ? r_len[r_rb] : '0;
   assign err    = r_err;

   // ------------------------------------------------------------------------
   // Bank ownership state machine (one FREE/FULL bit per bank)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state[0] <= FREE;
         r_state[1] <= FREE;
      end else begin
         r_state[0] <= w_state_nxt[0];
         r_state[1] <= w_state_nxt[1];
      end
   end

   // Commit and release never target the same bank: one needs FREE, the other FULL.
   always_comb begin
      w_state_nxt[0] = r_state[0];
      w_state_nxt[1] = r_state[1];
      if (w_commit) begin
         w_state_nxt[r_wb] = FULL;
      end
      if (w_release) begin
         w_state_nxt[r_rb] = FREE;
      end
   end

   // ------------------------------------------------------------------------
   // Bank pointers, fill counter, tile lengths, sticky error
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wb     <= 1'b0;
         r_rb     <= 1'b0;
         r_wcnt   <= '0;
         r_len[0] <= '0;
         r_len[1] <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_commit) begin
            r_len[r_wb] <= w_wcnt_inc;
            r_wb        <= ~r_wb;
            r_wcnt      <= '0;
         end else if (w_wr_acc) begin
            r_wcnt <= w_wcnt_inc;
         end
         if (w_release) begin
            r_rb <= ~r_rb;
         end
         if (w_any_err) begin
            r_err <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Storage banks: unreset write port and read register per bank
   // ------------------------------------------------------------------------
   for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      logic [DWIDTH-1:0] mem [MEM_SIZE];
      logic [DWIDTH-1:0] r_q;

      always_ff @(posedge clk) begin
         if (w_wr_acc && (r_wb == 1'(gi))) begin
            mem[wr_addr] <= wr_data;
         end
      end

      always_ff @(posedge clk) begin
         if (w_rd_acc && (r_rb == 1'(gi))) begin
            r_q <= mem[rd_addr];
         end
      end

      assign w_bank_q[gi] = r_q;
   end

   // Read tracking; r_rd_any forces rd_data to zero until the first read after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_valid <= 1'b0;
         r_rd_sel   <= 1'b0;
         r_rd_any   <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_acc;
         if (w_rd_acc) begin
            r_rd_sel <= r_rb;
            r_rd_any <= 1'b1;
         end
      end
   end

   assign w_ram_data = r_rd_any ? w_bank_q[r_rd_sel] : '0;

`ifdef ACT_IDX_OUT_REG_EN
   logic [DWIDTH-1:0] r_out_data;
   logic              r_out_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= r_rd_valid;
         if (r_rd_valid) begin
            r_out_data <= w_ram_data;
         end
      end
   end

   assign rd_data  = r_out_data;
   assign rd_valid = r_out_valid;
`else
   assign rd_data  = w_ram_data;
   assign rd_valid = r_rd_valid;
`endif

endmodule

`default_nettype wire
